addr8u_share_ctrl: RTL and testbench
====================================

Name: addr8u_share_ctrl

Overview:
Time-multiplexes one external combinational 8-bit unsigned adder (A[7:0] + B[7:0] -> O[8:0]) between NREQ requesters under round-robin arbitration. Each accepted operation runs twice for fault detection: once with operands as given, once with them swapped. The two results are compared, and the operation is retried on mismatch. The block sits between the client ports and the adder instance, and drives the adder's operand pins directly.

Parameters:
NREQ, 4, number of requester ports (2..8)
SETTLE_CYC, 1, clock cycles the operands are held on the adder before the result is sampled (1..4)
MAX_RETRY, 2, extra pass pairs allowed after a mismatch before an error is reported (0..7)

Ports:
clk  in  1  system clock; all state changes on its rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester operation request
req_a  in  8*NREQ  operand A, requester i at bits [8i+7:8i]
req_b  in  8*NREQ  operand B, same packing
req_ready  out  NREQ  one-hot accept pulse
add_a  out  8  operand A to the adder
add_b  out  8  operand B to the adder
add_o  in  9  sum from the adder
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts the result
rsp_id  out  3  index of the requester being served
rsp_sum  out  9  result
rsp_err  out  1  result unverified (passes disagreed)
err_cnt  out  8  saturating count of mismatching pass pairs since reset

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, rr pointer=0, retry count=0, err_cnt=0. All outputs are 0: req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_err. Reset overrides any state, including an operation in progress or a pending response; the operation is dropped with no response.
- States: IDLE, PASS1, PASS2, RESP.
- IDLE
  - If any req_valid is set, grant the first asserted index searching from rr pointer upward, wrapping modulo NREQ.
  - req_ready[g]=1 combinationally in that cycle only. A and B are latched at the edge, and rsp_id=g.
  - Next state PASS1, retry count=0. With no valid request, stay in IDLE.
  - req_ready is 0 in every other state.
- PASS1
  - add_a=A, add_b=B for SETTLE_CYC cycles.
  - On the last cycle, capture add_o into R1, then go to PASS2.
- PASS2
  - add_a=B, add_b=A for SETTLE_CYC cycles.
  - On the last cycle, compare add_o with R1.
  - Equal: rsp_sum=R1, rsp_err=0, go to RESP.
  - Unequal: err_cnt increments, saturating at 255.
    - If retry count < MAX_RETRY: increment retry count and go to PASS1.
    - Otherwise: rsp_sum=R1, rsp_err=1, go to RESP.
- In IDLE and RESP, add_a and add_b hold their last driven values.
- Latency from grant to rsp_valid with no faults: 2*SETTLE_CYC+1 cycles. Each retry adds 2*SETTLE_CYC cycles.
- RESP
  - rsp_valid=1, and rsp_id, rsp_sum and rsp_err are held stable until rsp_valid && rsp_ready at an edge.
  - At that edge: rsp_valid=0, rr pointer=(g+1) mod NREQ, go to IDLE.
  - rsp_ready high in RESP's first cycle completes it in one cycle.
  - A new grant happens at the earliest in the cycle after returning to IDLE.
- Requesters drop req_valid or change operands freely when not granted. Operands are sampled only at the grant edge.
- Arithmetic: the sum is 9-bit unsigned with no truncation, e.g. 0xFF+0xFF=0x1FE.
- If rsp_ready is high outside RESP, it is ignored.

Test Plan:
- Reset, then requester 1 alone with A=0x3C, B=0x5A, SETTLE_CYC=1 -> req_ready=0b0010 for one cycle; rsp_valid 3 cycles later with rsp_id=1, rsp_sum=0x096, rsp_err=0.
- All four req_valid held high, rsp_ready tied high -> grants in the order 0,1,2,3,0; each req_ready is one-hot with no double grant.
- Boundary sums: 0xFF+0xFF -> 0x1FE; 0x00+0x00 -> 0x000; 0x80+0x80 -> 0x100; all with rsp_err=0.
- Fault model: the adder stub forces O[3]=1 only when add_a=0x01, with A=0x01, B=0x02, MAX_RETRY=2 -> three pass pairs, rsp_err=1, rsp_sum=0x00B, err_cnt=3. A transient fault on the first pass pair only -> rsp_err=0, rsp_sum=0x003, err_cnt=1.
- Hold rsp_ready=0 for 10 cycles in RESP while other requests are pending -> outputs stable, no req_ready; the next grant occurs in the cycle after the handshake cycle.
- Assert rst during PASS2, and again during RESP -> next cycle all outputs are 0 and state is IDLE; no stale response is emitted, and the next grant starts from index 0.

Source files
------------

// File: rtl/addr8u_share_ctrl_if.sv
// Request/response bundle for the shared 8-bit adder controller.
// The master drives requests and consumes responses.
interface addr8u_share_ctrl_if #(
  parameter int NREQ = 4
) ();
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [2:0]        rsp_id;
  logic [8:0]        rsp_sum;
  logic              rsp_err;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_err
  );
endinterface

// File: rtl/addr8u_share_ctrl.sv
// Round-robin sharing of one external 8-bit adder; every operation
// runs twice with swapped operands and is retried when passes disagree.
module addr8u_share_ctrl #(
  parameter int NREQ       = 4,
  parameter int SETTLE_CYC = 1,
  parameter int MAX_RETRY  = 2
) (
  input  logic                clk,
  input  logic                rst,
  addr8u_share_ctrl_if.slave  bus,
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  input  logic [8:0]          add_o,
  output logic [7:0]          err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    PASS1,
    PASS2,
    RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]      r_rr;
  logic [2:0]      r_id;
  logic [2:0]      r_retry;
  logic [1:0]      r_cnt;
  logic [7:0]      r_a;
  logic [7:0]      r_b;
  logic [7:0]      r_add_a;
  logic [7:0]      r_add_b;
  logic [8:0]      r_r1;
  logic [8:0]      r_sum;
  logic            r_err;
  logic [7:0]      r_errc;

  logic            w_found;
  int              w_idx;
  int              w_gi;
  logic [2:0]      w_gnt;
  logic [NREQ-1:0] w_ready;
  logic            w_last;
  logic            w_match;
  logic            w_can_retry;

  // Search for the first valid requester from the rr pointer upward.
  always_comb begin
    w_found = 1'b0;
    w_idx   = 0;
    w_gi    = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = (int'(r_rr) + k) % NREQ;
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gi    = w_idx;
      end
    end
    w_gnt = w_gi[2:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic and the one-hot accept pulse.
  always_comb begin
    w_next      = r_state;
    w_ready     = '0;
    w_last      = (r_cnt == 2'(SETTLE_CYC - 1));
    w_match     = (add_o == r_r1);
    w_can_retry = (r_retry < 3'(MAX_RETRY));
    unique case (r_state)
      IDLE: begin
        if (w_found && !rst) begin
          w_next = PASS1;
          for (int i = 0; i < NREQ; i++)
            w_ready[i] = (w_gi == i);
        end
      end
      PASS1: begin
        if (w_last) w_next = PASS2;
      end
      PASS2: begin
        if (w_last) begin
          if (w_match || !w_can_retry)
            w_next = RESP;
          else
            w_next = PASS1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, pass sequencing, checking and response data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr    <= '0;
      r_id    <= '0;
      r_retry <= '0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_add_a <= '0;
      r_add_b <= '0;
      r_r1    <= '0;
      r_sum   <= '0;
      r_err   <= 1'b0;
      r_errc  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_found) begin
            r_a     <= bus.req_a[8*w_gi +: 8];
            r_b     <= bus.req_b[8*w_gi +: 8];
            r_add_a <= bus.req_a[8*w_gi +: 8];
            r_add_b <= bus.req_b[8*w_gi +: 8];
            r_id    <= w_gnt;
            r_retry <= '0;
            r_cnt   <= '0;
          end
        end
        PASS1: begin
          if (w_last) begin
            r_r1    <= add_o;
            r_cnt   <= '0;
            r_add_a <= r_b;
            r_add_b <= r_a;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        PASS2: begin
          if (w_last) begin
            r_cnt <= '0;
            if (w_match) begin
              r_sum <= r_r1;
              r_err <= 1'b0;
            end else begin
              if (r_errc != 8'hFF) r_errc <= r_errc + 8'd1;
              if (w_can_retry) begin
                r_retry <= r_retry + 3'd1;
                r_add_a <= r_a;
                r_add_b <= r_b;
              end else begin
                r_sum <= r_r1;
                r_err <= 1'b1;
              end
            end
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready)
            r_rr <= (r_id == 3'(NREQ - 1)) ? 3'd0 : r_id + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_id    = r_id;
  assign bus.rsp_sum   = r_sum;
  assign bus.rsp_err   = r_err;
  assign add_a         = r_add_a;
  assign add_b         = r_add_b;
  assign err_cnt       = r_errc;

endmodule

// File: tb/tb_addr8u_share_ctrl.sv
// Directed bench for addr8u_share_ctrl with an adder stub that can
// inject a stuck-at-one on bit 3 whenever add_a is 0x01.
module tb_addr8u_share_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic [8:0] add_o;
  logic [7:0] err_cnt;
  logic       fault_on;

  int n_cmp;
  int n_err;

  addr8u_share_ctrl_if #(.NREQ(4)) bus ();

  addr8u_share_ctrl #(
    .NREQ(4),
    .SETTLE_CYC(1),
    .MAX_RETRY(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .add_a(add_a),
    .add_b(add_b),
    .add_o(add_o),
    .err_cnt(err_cnt)
  );

  assign add_o = ({1'b0, add_a} + {1'b0, add_b})
               | ((fault_on && add_a == 8'h01) ? 9'h008 : 9'h000);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".rdy"}, 32'(bus.req_ready), 32'h0);
    chk({tag, ".adda"}, 32'(add_a), 32'h0);
    chk({tag, ".addb"}, 32'(add_b), 32'h0);
    chk({tag, ".vld"}, 32'(bus.rsp_valid), 32'h0);
    chk({tag, ".id"}, 32'(bus.rsp_id), 32'h0);
    chk({tag, ".sum"}, 32'(bus.rsp_sum), 32'h0);
    chk({tag, ".err"}, 32'(bus.rsp_err), 32'h0);
    chk({tag, ".ecnt"}, 32'(err_cnt), 32'h0);
  endtask

  task automatic run_op(input string tag, input int r,
                        input logic [7:0] a, input logic [7:0] b,
                        input int npairs, input int fpairs,
                        input logic [8:0] esum, input logic eerr);
    bus.req_valid = '0;
    bus.req_valid[r] = 1'b1;
    bus.req_a[8*r +: 8] = a;
    bus.req_b[8*r +: 8] = b;
    #1;
    chk({tag, ".gnt"}, 32'(bus.req_ready), 32'(1 << r));
    tick();
    bus.req_valid = '0;
    for (int p = 0; p < npairs; p++) begin
      fault_on = (p < fpairs);
      #1;
      if (p == 0) begin
        chk({tag, ".p1a"}, 32'(add_a), 32'(a));
        chk({tag, ".p1b"}, 32'(add_b), 32'(b));
      end
      tick();
      if (p == 0) chk({tag, ".p2a"}, 32'(add_a), 32'(b));
      tick();
    end
    fault_on = 1'b0;
    chk({tag, ".vld"}, 32'(bus.rsp_valid), 32'h1);
    chk({tag, ".id"}, 32'(bus.rsp_id), 32'(r));
    chk({tag, ".sum"}, 32'(bus.rsp_sum), 32'(esum));
    chk({tag, ".err"}, 32'(bus.rsp_err), 32'(eerr));
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk({tag, ".done"}, 32'(bus.rsp_valid), 32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    fault_on = 1'b0;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // Single requester, nominal latency.
    bus.req_valid = 4'b0010;
    bus.req_a[15:8] = 8'h3C;
    bus.req_b[15:8] = 8'h5A;
    #1;
    chk("t1.gnt", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    chk("t1.p1rdy", 32'(bus.req_ready), 32'h0);
    chk("t1.p1a", 32'(add_a), 32'h3C);
    chk("t1.p1b", 32'(add_b), 32'h5A);
    chk("t1.p1v", 32'(bus.rsp_valid), 32'h0);
    tick();
    chk("t1.p2a", 32'(add_a), 32'h5A);
    chk("t1.p2b", 32'(add_b), 32'h3C);
    chk("t1.p2v", 32'(bus.rsp_valid), 32'h0);
    tick();
    chk("t1.vld", 32'(bus.rsp_valid), 32'h1);
    chk("t1.id", 32'(bus.rsp_id), 32'h1);
    chk("t1.sum", 32'(bus.rsp_sum), 32'h096);
    chk("t1.err", 32'(bus.rsp_err), 32'h0);
    chk("t1.hold_a", 32'(add_a), 32'h5A);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("t1.done", 32'(bus.rsp_valid), 32'h0);

    // Round robin from a fresh reset, rsp_ready tied high.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_a = 32'h40302010;
    bus.req_b = 32'h04030201;
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr.gnt", 32'(bus.req_ready), 32'(1 << (i % 4)));
      tick();
      chk("rr.p1", 32'(bus.req_ready), 32'h0);
      tick();
      chk("rr.p2", 32'(bus.req_ready), 32'h0);
      tick();
      chk("rr.resp", 32'(bus.req_ready), 32'h0);
      chk("rr.id", 32'(bus.rsp_id), 32'(i % 4));
      chk("rr.sum", 32'(bus.rsp_sum), 32'(9'h11 * 9'((i % 4) + 1)));
      tick();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();

    // Boundary sums.
    run_op("ffff", 2, 8'hFF, 8'hFF, 1, 0, 9'h1FE, 1'b0);
    run_op("zero", 3, 8'h00, 8'h00, 1, 0, 9'h000, 1'b0);
    run_op("c80", 0, 8'h80, 8'h80, 1, 0, 9'h100, 1'b0);
    chk("nofault.ecnt", 32'(err_cnt), 32'h0);

    // Persistent fault exhausts the retries.
    run_op("perm", 1, 8'h01, 8'h02, 3, 99, 9'h00B, 1'b1);
    chk("perm.ecnt", 32'(err_cnt), 32'h3);

    // Transient fault on the first pass pair only.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_op("trans", 1, 8'h01, 8'h02, 2, 1, 9'h003, 1'b0);
    chk("trans.ecnt", 32'(err_cnt), 32'h1);

    // Back-pressure on the response with other requests pending.
    bus.req_a = 32'h40302010;
    bus.req_b = 32'h04030201;
    bus.req_valid = 4'b1111;
    #1;
    chk("bp.gnt", 32'(bus.req_ready), 32'h4);
    tick();
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp.vld", 32'(bus.rsp_valid), 32'h1);
      chk("bp.sum", 32'(bus.rsp_sum), 32'h033);
      chk("bp.id", 32'(bus.rsp_id), 32'h2);
      chk("bp.rdy", 32'(bus.req_ready), 32'h0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp.hs_rdy", 32'(bus.req_ready), 32'h0);
    tick();
    bus.rsp_ready = 1'b0;
    chk("bp.next", 32'(bus.req_ready), 32'h8);

    // Reset during PASS2.
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_zero("rst_p2");
    rst = 1'b0;
    #1;
    chk("rst_p2.gnt", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    chk("rst_resp.pre", 32'(bus.rsp_valid), 32'h1);

    // Reset during RESP.
    rst = 1'b1;
    tick();
    chk_zero("rst_resp");
    rst = 1'b0;
    tick();
    chk("rst_resp.stale", 32'(bus.rsp_valid), 32'h0);
    bus.req_valid = 4'b1111;
    #1;
    chk("rst_resp.gnt", 32'(bus.req_ready), 32'h1);
    bus.req_valid = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
